// File: rtl/seg_disp_sched_pkg.sv
// Shared definitions for the seven-segment display scheduler: display data width,
// clamp ceiling, scheduler state encoding and the clamp/overflow helpers.
package seg_disp_sched_pkg;

    localparam int DISP_DATA_W  = 15;
    localparam int DISP_MAX_VAL = 9999;
    localparam int OWNER_IDX_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_OPEN = 2'd2
    } sched_state_e;

    function automatic logic disp_is_over(input logic [DISP_DATA_W-1:0] v,
                                          input logic [DISP_DATA_W-1:0] maxVal);
        return (v > maxVal);
    endfunction

    // Values beyond four decimal digits saturate rather than wrap on the display.
    function automatic logic [DISP_DATA_W-1:0] disp_clamp(input logic [DISP_DATA_W-1:0] v,
                                                         input logic [DISP_DATA_W-1:0] maxVal);
        return (v > maxVal) ? maxVal : v;
    endfunction

endpackage

// File: rtl/seg_disp_sched_rr_pick.sv
// Combinational round-robin picker: scans N requesters starting at start_i, skipping
// any bit set in excl_i, and reports the first eligible one.
module rr_pick
    import seg_disp_sched_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = OWNER_IDX_W
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] start_i,
    input  logic [N-1:0]     excl_i,
    output logic [N-1:0]     winner_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [N-1:0] eligible;

    assign eligible = req_i & ~excl_i;

    always_comb begin
        winner_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = int'(start_i) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!any_o && eligible[j]) begin
                any_o       = 1'b1;
                winner_o[j] = 1'b1;
                idx_o       = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/seg_disp_sched.sv
// Shares the single 4-digit seven-segment display among N_REQ requesters using
// round-robin arbitration with a minimum dwell per owner; drives SegLed.data.
module seg_disp_sched
    import seg_disp_sched_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = DISP_DATA_W,
    parameter int HOLD_CYC = 24_000_000,
    parameter int MAX_VAL  = DISP_MAX_VAL
) (
    input  logic                    clk_24m,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        grant,
    output logic [2:0]              owner_idx,
    output logic [DATA_W-1:0]       disp_data,
    output logic                    disp_valid,
    output logic                    disp_ovf
);

    localparam int               CNT_W      = $clog2(HOLD_CYC + 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(HOLD_CYC - 1);
    localparam logic [2:0]       LAST_IDX   = 3'(N_REQ - 1);
    localparam logic [DATA_W-1:0] MAX_V     = DATA_W'(MAX_VAL);

    sched_state_e      state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [2:0]        ownerIdx_q, ownerIdx_d;
    logic [2:0]        lastOwner_q, lastOwner_d;
    logic [CNT_W-1:0]  dwell_q, dwell_d;
    logic [DATA_W-1:0] dispData_q, dispData_d;
    logic              dispValid_q, dispValid_d;
    logic              dispOvf_q, dispOvf_d;

    logic [2:0]        pickBase;
    logic [2:0]        pickStart;
    logic [N_REQ-1:0]  pickExcl;
    logic [N_REQ-1:0]  pickOnehot;
    logic [2:0]        pickIdx;
    logic              pickAny;
    logic              ownerReq;
    logic              takeNew;
    logic              goIdle;
    logic [DATA_W-1:0] selVal;

    // When idle the scan resumes after the previous owner; while granted it starts
    // after the current owner and never re-picks it.
    assign pickBase  = (state_q == ST_IDLE) ? lastOwner_q : ownerIdx_q;
    assign pickStart = (pickBase >= LAST_IDX) ? 3'd0 : (pickBase + 3'd1);
    assign pickExcl  = (state_q == ST_IDLE) ? '0 : grant_q;
    assign ownerReq  = |(req & grant_q);

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (3)
    ) u_rr_pick (
        .req_i    (req),
        .start_i  (pickStart),
        .excl_i   (pickExcl),
        .winner_o (pickOnehot),
        .idx_o    (pickIdx),
        .any_o    (pickAny)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ownerIdx_d  = ownerIdx_q;
        lastOwner_d = lastOwner_q;
        dwell_d     = dwell_q;
        takeNew     = 1'b0;
        goIdle      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                takeNew = pickAny;
            end
            // An owner that lets go aborts its dwell; otherwise the dwell must run out.
            ST_HOLD: begin
                if (!ownerReq) begin
                    takeNew = pickAny;
                    goIdle  = !pickAny;
                end else if (dwell_q == '0) begin
                    state_d = ST_OPEN;
                end else begin
                    dwell_d = dwell_q - CNT_W'(1);
                end
            end
            ST_OPEN: begin
                takeNew = pickAny;
                goIdle  = !pickAny && !ownerReq;
            end
            default: begin
                goIdle = 1'b1;
            end
        endcase

        if (takeNew) begin
            if (state_q != ST_IDLE) begin
                lastOwner_d = ownerIdx_q;
            end
            grant_d    = pickOnehot;
            ownerIdx_d = pickIdx;
            dwell_d    = DWELL_LOAD;
            state_d    = ST_HOLD;
        end

        if (goIdle) begin
            lastOwner_d = ownerIdx_q;
            grant_d     = '0;
            ownerIdx_d  = '0;
            dwell_d     = '0;
            state_d     = ST_IDLE;
        end
    end

    // The display tracks the next owner's live value, so a new grant shows its data at once.
    always_comb begin
        selVal = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_d[i]) begin
                selVal = selVal | req_data[i*DATA_W +: DATA_W];
            end
        end
        dispValid_d = (state_d != ST_IDLE);
        dispData_d  = dispValid_d ? disp_clamp(selVal, MAX_V) : '0;
        dispOvf_d   = dispValid_d ? disp_is_over(selVal, MAX_V) : 1'b0;
    end

    always_ff @(posedge clk_24m) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            ownerIdx_q  <= '0;
            lastOwner_q <= LAST_IDX;
            dwell_q     <= '0;
            dispData_q  <= '0;
            dispValid_q <= 1'b0;
            dispOvf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ownerIdx_q  <= ownerIdx_d;
            lastOwner_q <= lastOwner_d;
            dwell_q     <= dwell_d;
            dispData_q  <= dispData_d;
            dispValid_q <= dispValid_d;
            dispOvf_q   <= dispOvf_d;
        end
    end

    assign grant      = grant_q;
    assign owner_idx  = ownerIdx_q;
    assign disp_data  = dispData_q;
    assign disp_valid = dispValid_q;
    assign disp_ovf   = dispOvf_q;

endmodule

// File: tb/tb_seg_disp_sched.sv
// Testbench for seg_disp_sched with a short dwell: table vectors, hand-built
// arbitration sequences and a randomized run against a behavioural model.
module tb_seg_disp_sched;

    localparam int N    = 4;
    localparam int DW   = 15;
    localparam int HOLD = 8;
    localparam int MAXV = 9999;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [59:0] data;
        logic [3:0]  expGrant;
        logic [2:0]  expIdx;
        logic        expValid;
        logic [14:0] expData;
        logic        expOvf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [59:0] reqData;
    logic [3:0]  grant;
    logic [2:0]  ownerIdx;
    logic [14:0] dispData;
    logic        dispValid;
    logic        dispOvf;

    int assertCount = 0;
    int failCount   = 0;

    int          mOwner;
    int          mLast;
    int          mElapsed;
    logic [14:0] mData;
    logic        mOvf;

    vec_t vecs [11];

    seg_disp_sched #(
        .N_REQ    (N),
        .DATA_W   (DW),
        .HOLD_CYC (HOLD),
        .MAX_VAL  (MAXV)
    ) dut (
        .clk_24m    (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (reqData),
        .grant      (grant),
        .owner_idx  (ownerIdx),
        .disp_data  (dispData),
        .disp_valid (dispValid),
        .disp_ovf   (dispOvf)
    );

    always #5 clk = ~clk;

    function automatic logic [59:0] pk(input int d0, input int d1, input int d2, input int d3);
        return {15'(d3), 15'(d2), 15'(d1), 15'(d0)};
    endfunction

    function automatic logic [14:0] sliceOf(input logic [59:0] d, input int i);
        return d[i*15 +: 15];
    endfunction

    // First requester after 'from' in circular order, skipping 'excl'; -1 when none.
    function automatic int rrNext(input int from, input logic [3:0] r, input int excl);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (from + k) % N;
            if (j != excl && r[j]) return j;
        end
        return -1;
    endfunction

    // Model tracks only who owns the display and how many edges it has held it.
    task automatic modelStep(input logic r, input logic [3:0] rq, input logic [59:0] d);
        int          nxt;
        logic        others;
        logic        ownerHeld;
        logic [14:0] v;
        if (r) begin
            mOwner   = -1;
            mLast    = N - 1;
            mElapsed = 0;
        end else if (mOwner < 0) begin
            nxt = rrNext(mLast, rq, -1);
            if (nxt >= 0) begin
                mOwner   = nxt;
                mElapsed = 0;
            end
        end else begin
            others    = (rq & ~(4'b0001 << mOwner)) != 4'b0000;
            ownerHeld = rq[mOwner];
            if (!ownerHeld || (mElapsed >= HOLD && others)) begin
                mLast = mOwner;
                if (others) begin
                    mOwner   = rrNext(mLast, rq, mLast);
                    mElapsed = 0;
                end else begin
                    mOwner = -1;
                end
            end else begin
                mElapsed = mElapsed + 1;
            end
        end
        if (mOwner >= 0) begin
            v     = sliceOf(d, mOwner);
            mOvf  = (v > 15'(MAXV));
            mData = mOvf ? 15'(MAXV) : v;
        end else begin
            mData = '0;
            mOvf  = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [59:0] d);
        rst     = r;
        req     = rq;
        reqData = d;
        @(posedge clk);
        #1;
        modelStep(r, rq, d);
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [3:0] expGrant;
        expGrant = (mOwner >= 0) ? (4'b0001 << mOwner) : 4'b0000;
        checkVal({tag, ".grant"}, 32'(grant), 32'(expGrant));
        checkVal({tag, ".owner_idx"}, 32'(ownerIdx), (mOwner >= 0) ? 32'(mOwner) : 32'd0);
        checkVal({tag, ".disp_valid"}, 32'(dispValid), 32'(mOwner >= 0));
        checkVal({tag, ".disp_data"}, 32'(dispData), 32'(mData));
        checkVal({tag, ".disp_ovf"}, 32'(dispOvf), 32'(mOvf));
    endtask

    initial begin
        logic [3:0]  rq;
        logic [59:0] d;
        int          own;

        rst     = 1'b1;
        req     = '0;
        reqData = '0;
        mOwner  = -1;
        mLast   = N - 1;
        mElapsed = 0;
        mData   = '0;
        mOvf    = 1'b0;

        // Vectors run back to back, so each row's expectation assumes the rows before it.
        vecs[0]  = '{1'b1, 4'b0000, pk(0, 0, 0, 0),        4'b0000, 3'd0, 1'b0, 15'd0,    1'b0};
        vecs[1]  = '{1'b0, 4'b0001, pk(1234, 0, 0, 0),     4'b0001, 3'd0, 1'b1, 15'd1234, 1'b0};
        vecs[2]  = '{1'b0, 4'b0001, pk(12000, 0, 0, 0),    4'b0001, 3'd0, 1'b1, 15'd9999, 1'b1};
        vecs[3]  = '{1'b0, 4'b0001, pk(42, 0, 0, 0),       4'b0001, 3'd0, 1'b1, 15'd42,   1'b0};
        vecs[4]  = '{1'b0, 4'b0001, pk(9999, 0, 0, 0),     4'b0001, 3'd0, 1'b1, 15'd9999, 1'b0};
        vecs[5]  = '{1'b0, 4'b0001, pk(10000, 0, 0, 0),    4'b0001, 3'd0, 1'b1, 15'd9999, 1'b1};
        vecs[6]  = '{1'b0, 4'b0001, pk(32767, 0, 0, 0),    4'b0001, 3'd0, 1'b1, 15'd9999, 1'b1};
        vecs[7]  = '{1'b0, 4'b0001, pk(0, 0, 0, 0),        4'b0001, 3'd0, 1'b1, 15'd0,    1'b0};
        vecs[8]  = '{1'b0, 4'b0000, pk(0, 0, 0, 0),        4'b0000, 3'd0, 1'b0, 15'd0,    1'b0};
        vecs[9]  = '{1'b0, 4'b0010, pk(0, 77, 0, 0),       4'b0010, 3'd1, 1'b1, 15'd77,   1'b0};
        vecs[10] = '{1'b0, 4'b0011, pk(5, 77, 0, 0),       4'b0010, 3'd1, 1'b1, 15'd77,   1'b0};

        applyStimulus(1'b1, 4'b0000, '0);
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].data);
            checkVal($sformatf("vec%0d.grant", i), 32'(grant), 32'(vecs[i].expGrant));
            checkVal($sformatf("vec%0d.owner_idx", i), 32'(ownerIdx), 32'(vecs[i].expIdx));
            checkVal($sformatf("vec%0d.disp_valid", i), 32'(dispValid), 32'(vecs[i].expValid));
            checkVal($sformatf("vec%0d.disp_data", i), 32'(dispData), 32'(vecs[i].expData));
            checkVal($sformatf("vec%0d.disp_ovf", i), 32'(dispOvf), 32'(vecs[i].expOvf));
        end

        // Pending requester waits out the full dwell, then takes over with its own data.
        applyStimulus(1'b1, 4'b0000, '0);
        applyStimulus(1'b0, 4'b0001, pk(100, 0, 555, 0));
        checkVal("dwell.first", 32'(grant), 32'(4'b0001));
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b0, 4'b0101, pk(100, 0, 555, 0));
            checkVal($sformatf("dwell.hold%0d", k), 32'(grant), 32'(4'b0001));
        end
        applyStimulus(1'b0, 4'b0101, pk(100, 0, 555, 0));
        checkVal("dwell.switch.grant", 32'(grant), 32'(4'b0100));
        checkVal("dwell.switch.idx", 32'(ownerIdx), 32'd2);
        checkVal("dwell.switch.data", 32'(dispData), 32'd555);
        applyStimulus(1'b0, 4'b0101, pk(100, 0, 600, 0));
        checkVal("dwell.track.data", 32'(dispData), 32'd600);

        // All four requesting: ownership rotates every HOLD+1 edges.
        applyStimulus(1'b1, 4'b0000, '0);
        for (int k = 0; k < 45; k++) begin
            applyStimulus(1'b0, 4'b1111, pk(10, 20, 30, 40));
            own = (k / (HOLD + 1)) % N;
            checkVal($sformatf("rotate%0d.grant", k), 32'(grant), 32'(4'b0001 << own));
            checkVal($sformatf("rotate%0d.data", k), 32'(dispData), 32'((own + 1) * 10));
        end

        // Owner releases mid-dwell with nobody waiting, then comes back alone.
        applyStimulus(1'b1, 4'b0000, '0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 4'b0001, pk(321, 0, 0, 0));
        end
        checkVal("release.before", 32'(grant), 32'(4'b0001));
        applyStimulus(1'b0, 4'b0000, pk(321, 0, 0, 0));
        checkVal("release.grant", 32'(grant), 32'd0);
        checkVal("release.valid", 32'(dispValid), 32'd0);
        checkVal("release.data", 32'(dispData), 32'd0);
        applyStimulus(1'b0, 4'b0001, pk(321, 0, 0, 0));
        checkVal("release.regrant", 32'(grant), 32'(4'b0001));

        // Reset mid-dwell drops everything; afterwards requester 0 wins first.
        applyStimulus(1'b1, 4'b0000, '0);
        applyStimulus(1'b0, 4'b0010, pk(0, 321, 0, 0));
        checkVal("rst.owner1", 32'(grant), 32'(4'b0010));
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 4'b0010, pk(0, 321, 0, 0));
        end
        applyStimulus(1'b1, 4'b0010, pk(0, 321, 0, 0));
        checkVal("rst.grant", 32'(grant), 32'd0);
        checkVal("rst.idx", 32'(ownerIdx), 32'd0);
        checkVal("rst.valid", 32'(dispValid), 32'd0);
        checkVal("rst.data", 32'(dispData), 32'd0);
        checkVal("rst.ovf", 32'(dispOvf), 32'd0);
        applyStimulus(1'b0, 4'b0011, pk(11, 321, 0, 0));
        checkVal("rst.first", 32'(grant), 32'(4'b0001));

        // Randomized traffic against the behavioural model.
        applyStimulus(1'b1, 4'b0000, '0);
        rq = '0;
        d  = '0;
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                rq[$urandom_range(0, 3)] ^= 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 1) == 0) begin
                        d[i*15 +: 15] = 15'($urandom_range(0, 32767));
                    end else begin
                        d[i*15 +: 15] = 15'($urandom_range(9990, 10010));
                    end
                end
            end
            applyStimulus(($urandom_range(0, 399) == 0), rq, d);
            checkOutput($sformatf("rand%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
